// File: rtl/inert_rd_seq_if.sv
// SPI-monarch command bus between the inertial read sequencer and the
// SPI monarch: transaction start strobe + command word going out,
// completion pulse + read byte coming back.
interface inert_rd_seq_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/inert_rd_seq.sv
// Inertial sensor command sequencer.
// After power-up it waits 2^INIT_WAIT_W-1 cycles, writes four configuration
// words through the SPI monarch, then on every data-ready interrupt reads the
// pitch/roll/yaw rate bytes (low byte first) and presents them as signed
// 16-bit words together with a one-cycle vld strobe.
// Optional build macro INERT_ACCEL_EN extends the burst with the X/Y accel
// bytes and adds the ax/ay outputs.
module inert_rd_seq #(
  parameter int INIT_WAIT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               INT,
  inert_rd_seq_if.master     spi,
  output logic signed [15:0] ptch,
  output logic signed [15:0] roll,
  output logic signed [15:0] yaw,
`ifdef INERT_ACCEL_EN
  output logic signed [15:0] ax,
  output logic signed [15:0] ay,
`endif
  output logic               vld,
  output logic               init_done
);

`ifdef INERT_ACCEL_EN
  localparam int NUM_RD = 10;
`else
  localparam int NUM_RD = 6;
`endif
  localparam logic [3:0] LAST_RD = 4'(NUM_RD - 1);
  // Transition value: the counter reaches all-ones on the same edge that
  // moves the FSM into INIT_WR.
  localparam logic [INIT_WAIT_W-1:0] WAIT_LAST = {{(INIT_WAIT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_WR,
    INIT_WT,
    IDLE,
    RD_ISSUE,
    RD_WT,
    UPDATE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [INIT_WAIT_W-1:0] wait_cnt;
  logic [1:0]             idx;
  logic [3:0]             ridx;
  logic                   int_s1;
  logic                   int_s2;
  logic                   int_s3;
  logic                   rise;
  logic                   pending;
  logic                   burst_state;
  logic                   last_done;
  logic [7:0]             last_byte;
  // The final byte of a burst goes straight to the outputs, so only the
  // earlier bytes need holding.
  logic [7:0]             byte_q [0:NUM_RD-2];
  logic [7:0]             unused_rd_hi;

  function automatic logic [15:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 16'h0D02;  // INT pin on data ready
      2'd1:    init_cmd = 16'h1062;  // accel config
      2'd2:    init_cmd = 16'h1162;  // gyro config
      default: init_cmd = 16'h1460;  // rounding
    endcase
  endfunction

  function automatic logic [7:0] rd_addr(input logic [3:0] i);
    rd_addr = 8'hA2 + {4'h0, i};
  endfunction

  assign rise         = int_s2 & ~int_s3;
  assign burst_state  = (state == RD_ISSUE) || (state == RD_WT) || (state == UPDATE);
  assign last_done    = (state == RD_WT) && spi.done && (ridx == LAST_RD);
  assign last_byte    = spi.rd_data[7:0];
  assign unused_rd_hi = spi.rd_data[15:8];

  // Bring the asynchronous interrupt into the clock domain; third flop for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_s1 <= 1'b0;
      int_s2 <= 1'b0;
      int_s3 <= 1'b0;
    end else begin
      int_s1 <= INT;
      int_s2 <= int_s1;
      int_s3 <= int_s2;
    end
  end

  // Next-state and SPI command decode; wrt/cmd are Moore outputs of the issue states.
  always_comb begin
    state_nxt = state;
    spi.wrt   = 1'b0;
    spi.cmd   = 16'h0000;
    case (state)
      PWR_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = INIT_WR;
      INIT_WR: begin
        spi.wrt   = 1'b1;
        spi.cmd   = init_cmd(idx);
        state_nxt = INIT_WT;
      end
      INIT_WT: if (spi.done) state_nxt = (idx == 2'd3) ? IDLE : INIT_WR;
      IDLE: if (rise || pending) state_nxt = RD_ISSUE;
      RD_ISSUE: begin
        spi.wrt   = 1'b1;
        spi.cmd   = {rd_addr(ridx), 8'h00};
        state_nxt = RD_WT;
      end
      RD_WT: if (spi.done) state_nxt = (ridx == LAST_RD) ? UPDATE : RD_ISSUE;
      UPDATE: state_nxt = IDLE;
      default: state_nxt = PWR_WAIT;
    endcase
  end

  // Control state: FSM register, counters, indices, sticky init flag, pending interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWR_WAIT;
      wait_cnt  <= '0;
      idx       <= 2'd0;
      ridx      <= 4'd0;
      init_done <= 1'b0;
      pending   <= 1'b0;
      vld       <= 1'b0;
    end else begin
      state <= state_nxt;
      vld   <= last_done;
      case (state)
        PWR_WAIT: wait_cnt <= wait_cnt + 1'b1;
        INIT_WT: begin
          if (spi.done) begin
            if (idx == 2'd3) init_done <= 1'b1;
            else             idx       <= idx + 1'b1;
          end
        end
        IDLE: if (rise || pending) ridx <= 4'd0;
        RD_WT: if (spi.done && (ridx != LAST_RD)) ridx <= ridx + 1'b1;
        default: ;
      endcase
      // An edge during a burst is remembered and served right after it.
      if (burst_state && rise)              pending <= 1'b1;
      else if ((state == IDLE) && pending)  pending <= 1'b0;
    end
  end

  // Byte holding registers filled as each read completes.
  always_ff @(posedge clk) begin
    if ((state == RD_WT) && spi.done) begin
      for (int i = 0; i < NUM_RD - 1; i++) begin
        if (ridx == 4'(i)) byte_q[i] <= last_byte;
      end
    end
  end

  // Rate words load on the edge entering UPDATE so they are valid exactly while vld is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptch <= '0;
      roll <= '0;
      yaw  <= '0;
`ifdef INERT_ACCEL_EN
      ax   <= '0;
      ay   <= '0;
`endif
    end else if (last_done) begin
      ptch <= {byte_q[1], byte_q[0]};
      roll <= {byte_q[3], byte_q[2]};
`ifdef INERT_ACCEL_EN
      yaw  <= {byte_q[5], byte_q[4]};
      ax   <= {byte_q[7], byte_q[6]};
      ay   <= {last_byte, byte_q[8]};
`else
      yaw  <= {last_byte, byte_q[4]};
`endif
    end
  end

endmodule
